// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM responder model: default geometry,
// active-low enable constants, FSM encoding and a saturating counter helper.
package sram_pkg;

  localparam int unsigned AW_DEF = 10;
  localparam int unsigned DW_DEF = 8;

  localparam logic ENA    = 1'b0;
  localparam logic DISENA = 1'b1;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } sram_state_e;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-latency delay line of {valid, data}; stage 0 captures on the access edge.
module sram_rd_pipe #(
  parameter int unsigned LAT = 1,
  parameter int unsigned DW  = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  logic [LAT-1:0]         vld;
  logic [LAT-1:0][DW-1:0] dat;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld <= '0;
      dat <= '0;
    end else begin
      vld[0] <= in_valid;
      dat[0] <= in_data;
      for (int unsigned i = 1; i < LAT; i++) begin
        vld[i] <= vld[i-1];
        dat[i] <= dat[i-1];
      end
    end
  end

  assign out_valid = vld[LAT-1];
  assign out_data  = dat[LAT-1];

endmodule

// File: rtl/sram_model_resp.sv
// Cycle-accurate single-port SRAM responder: post-reset init sweep, active-low
// access decode, RD_LAT read pipe, saturating traffic counters, conflict flag.
module sram_model_resp
  import sram_pkg::*;
#(
  parameter int unsigned   AW       = AW_DEF,
  parameter int unsigned   DW       = DW_DEF,
  parameter int unsigned   RD_LAT   = 1,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          s_cen,
  input  logic          s_wen,
  input  logic          s_oen,
  input  logic [AW-1:0] s_addr,
  input  logic [DW-1:0] s_ddata,
  output logic [DW-1:0] s_qdata,
  output logic          ready,
  output logic [15:0]   wr_cnt,
  output logic [15:0]   rd_cnt,
  output logic [15:0]   drop_cnt,
  output logic          conflict
);

  logic [DW-1:0] mem [2**AW];

  sram_state_e   state, state_nxt;
  logic [AW-1:0] ptr, ptr_nxt;

  logic          run, acc, wr_fire, rd_fire, cf_fire, drop_fire;
  logic [DW-1:0] rd_data;
  logic          pipe_vld;
  logic [DW-1:0] pipe_dat;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_INIT;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      ST_INIT: begin
        ptr_nxt = ptr + AW'(1);
        if (ptr == '1) state_nxt = ST_RUN;
      end
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end

  assign run       = (state == ST_RUN);
  assign ready     = run;
  assign acc       = (s_cen == ENA);
  assign wr_fire   = run && acc && (s_wen == ENA);
  assign rd_fire   = run && acc && (s_wen == DISENA) && (s_oen == ENA);
  assign cf_fire   = run && acc && (s_wen == ENA) && (s_oen == ENA);
  assign drop_fire = !run && acc;
  assign rd_data   = mem[s_addr];

  // Array is never reset; the INIT sweep is what gives it a defined value.
  always_ff @(posedge clk) begin
    if (!run)
      mem[ptr] <= INIT_VAL;
    else if (wr_fire)
      mem[s_addr] <= s_ddata;
  end

  sram_rd_pipe #(
    .LAT (RD_LAT),
    .DW  (DW)
  ) u_rd_pipe (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (rd_fire),
    .in_data   (rd_data),
    .out_valid (pipe_vld),
    .out_data  (pipe_dat)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_qdata  <= '0;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      drop_cnt <= '0;
      conflict <= 1'b0;
    end else begin
      if (pipe_vld)  s_qdata  <= pipe_dat;
      if (wr_fire)   wr_cnt   <= sat_inc(wr_cnt);
      if (rd_fire)   rd_cnt   <= sat_inc(rd_cnt);
      if (drop_fire) drop_cnt <= sat_inc(drop_cnt);
      if (cf_fire)   conflict <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_model_resp.sv
// Directed bench for sram_model_resp: two instances (RD_LAT=1 and RD_LAT=3) share
// stimulus; a reference array and per-instance scoreboards predict read data.
module tb_sram_model_resp;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       s_cen = 1'b1, s_wen = 1'b1, s_oen = 1'b1;
  logic [9:0] s_addr = '0;
  logic [7:0] s_ddata = '0;

  logic [7:0]  q1, q3;
  logic        rdy1, rdy3, cf1, cf3;
  logic [15:0] wr1, wr3, rd1, rd3, dr1, dr3;

  always #5 clk = ~clk;

  sram_model_resp #(.AW(10), .DW(8), .RD_LAT(1), .INIT_VAL(8'h00)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .s_cen(s_cen), .s_wen(s_wen), .s_oen(s_oen),
    .s_addr(s_addr), .s_ddata(s_ddata), .s_qdata(q1), .ready(rdy1),
    .wr_cnt(wr1), .rd_cnt(rd1), .drop_cnt(dr1), .conflict(cf1));

  sram_model_resp #(.AW(10), .DW(8), .RD_LAT(3), .INIT_VAL(8'h00)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .s_cen(s_cen), .s_wen(s_wen), .s_oen(s_oen),
    .s_addr(s_addr), .s_ddata(s_ddata), .s_qdata(q3), .ready(rdy3),
    .wr_cnt(wr3), .rd_cnt(rd3), .drop_cnt(dr3), .conflict(cf3));

  typedef struct {
    int unsigned due;
    logic [7:0]  data;
  } exp_t;

  exp_t        sb1[$], sb3[$];
  logic [7:0]  ref_mem [1024];
  int unsigned cyc = 0;
  int unsigned tests = 0, fails = 0;
  bit          model_run = 1'b0;
  logic [15:0] wr_m = '0, rd_m = '0, drop_m = '0;
  logic        conf_m = 1'b0;
  logic [7:0]  last1 = '0, last3 = '0;
  int unsigned c_rel = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare each predicted read result on its due edge.
  always @(posedge clk) begin
    #1;
    while (sb1.size() > 0 && sb1[0].due == cyc) begin
      chk("qdata_lat1", q1, sb1[0].data);
      last1 = sb1[0].data;
      void'(sb1.pop_front());
    end
    while (sb3.size() > 0 && sb3[0].due == cyc) begin
      chk("qdata_lat3", q3, sb3[0].data);
      last3 = sb3[0].data;
      void'(sb3.pop_front());
    end
  end

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Drive one access for the next edge and predict its effect.
  task automatic step(input logic cen, input logic wen, input logic oen,
                      input logic [9:0] a, input logic [7:0] d);
    exp_t e;
    @(negedge clk);
    s_cen = cen; s_wen = wen; s_oen = oen; s_addr = a; s_ddata = d;
    if (cen == 1'b0) begin
      if (!model_run) drop_m = sat(drop_m);
      else if (wen == 1'b0) begin
        ref_mem[a] = d;
        wr_m = sat(wr_m);
        if (oen == 1'b0) conf_m = 1'b1;
      end else if (oen == 1'b0) begin
        e.data = ref_mem[a];
        e.due  = cyc + 1 + 1;
        sb1.push_back(e);
        e.due  = cyc + 1 + 3;
        sb3.push_back(e);
        rd_m = sat(rd_m);
      end
    end
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b1, 1'b1, 1'b1, 10'h000, 8'h00);
  endtask

  task automatic wr(input logic [9:0] a, input logic [7:0] d);
    step(1'b0, 1'b0, 1'b1, a, d);
  endtask

  task automatic rd(input logic [9:0] a);
    step(1'b0, 1'b1, 1'b0, a, 8'h00);
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_wr1"}, wr1, wr_m);   chk({tag, "_wr3"}, wr3, wr_m);
    chk({tag, "_rd1"}, rd1, rd_m);   chk({tag, "_rd3"}, rd3, rd_m);
    chk({tag, "_drop1"}, dr1, drop_m); chk({tag, "_drop3"}, dr3, drop_m);
    chk({tag, "_cf1"}, cf1, conf_m); chk({tag, "_cf3"}, cf3, conf_m);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_q1"}, q1, 8'h00);  chk({tag, "_q3"}, q3, 8'h00);
    chk({tag, "_rdy1"}, rdy1, 1'b0); chk({tag, "_rdy3"}, rdy3, 1'b0);
    chk_cnt(tag);
  endtask

  task automatic wait_ready(input string tag);
    while (rdy1 !== 1'b1 && (cyc - c_rel) < 3000) begin
      @(posedge clk);
      #1;
    end
    chk({tag, "_cycles"}, cyc - c_rel, 1024);
    chk({tag, "_rdy3"}, rdy3, 1'b1);
    for (int unsigned i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    model_run = 1'b1;
  endtask

  initial begin
    logic [7:0]  q1_hold, q3_hold;
    logic [15:0] rd_hold;

    // Reset state
    idle(3);
    #1;
    chk_reset("reset");

    // Release, with four accesses dropped during INIT
    @(negedge clk);
    reset_n = 1'b1;
    c_rel = cyc;
    wr(10'h001, 8'hEE); wr(10'h002, 8'hEE); wr(10'h003, 8'hEE); wr(10'h004, 8'hEE);
    idle(1);
    wait_ready("init");
    chk("drop1", dr1, 16'd4);
    chk("drop3", dr3, 16'd4);

    // Write then read the top address
    wr(10'h3FF, 8'hA5);
    rd(10'h3FF);
    idle(5);
    chk("t2_wr1", wr1, 16'd1);
    chk("t2_rd1", rd1, 16'd1);
    chk("t2_q1", q1, 8'hA5);

    // Addresses written during INIT still hold INIT_VAL; random reads are INIT_VAL
    for (int unsigned i = 1; i <= 4; i++) rd(10'(i));
    for (int unsigned i = 0; i < 4; i++) rd(10'($urandom_range(5, 1000)));
    idle(5);

    // Back-to-back reads after a write burst
    for (int unsigned i = 0; i < 4; i++) wr(10'(i), 8'h10 + 8'(i));
    for (int unsigned i = 0; i < 4; i++) rd(10'(i));
    idle(5);
    chk_cnt("t3");

    // Write/read conflict on the same edge
    q1_hold = last1;
    q3_hold = last3;
    rd_hold = rd_m;
    step(1'b0, 1'b0, 1'b0, 10'h005, 8'h5A);
    idle(4);
    chk("t4_cf1", cf1, 1'b1);
    chk("t4_rd1", rd1, rd_hold);
    chk("t4_q1_hold", q1, q1_hold);
    chk("t4_q3_hold", q3, q3_hold);
    rd(10'h005);
    step(1'b0, 1'b1, 1'b1, 10'h006, 8'hFF);
    idle(5);
    chk_cnt("t4");

    // Reset mid-RUN with reads in flight
    rd(10'h3FF); rd(10'h000); rd(10'h001);
    @(negedge clk);
    reset_n = 1'b0;
    s_cen = 1'b1; s_wen = 1'b1; s_oen = 1'b1;
    sb1.delete(); sb3.delete();
    model_run = 1'b0;
    wr_m = '0; rd_m = '0; drop_m = '0; conf_m = 1'b0;
    last1 = '0; last3 = '0;
    #1;
    chk_reset("t6");
    idle(2);
    @(negedge clk);
    reset_n = 1'b1;
    c_rel = cyc;
    wait_ready("rerun");
    rd(10'h3FF); rd(10'h000);
    idle(6);
    chk_cnt("end");
    chk("sb_drain", sb1.size() + sb3.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
